layer_serializer: RTL and testbench
===================================

LAYER_SERIALIZER -- requirements
Module: layer_serializer

Interface
REQ-001 SHALL have parameter NN, default 30: neurons per frame (words per parallel input vector), range 1..1024.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: bits per neuron word.
REQ-003 SHALL have parameter NUM_BUF, default 2: frame buffers held, 1 (single) or 2 (ping-pong).
REQ-004 SHALL have port clk  input  1: the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid  input  1: one-cycle pulse, frame present on in_data.
REQ-007 SHALL have port in_data  input  NN*DATA_WIDTH: neuron k in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port in_ready  output  1: a frame offered this cycle will be captured.
REQ-009 SHALL have port out_data  output  DATA_WIDTH: current serial word.
REQ-010 SHALL have port out_valid  output  1: out_data valid.
REQ-011 SHALL have port out_ready  input  1: downstream accepts; a word transfers when out_valid && out_ready.
REQ-012 SHALL have port out_last  output  1: current word is neuron NN-1 of its frame.
REQ-013 SHALL have port out_idx  output  clog2(NN) (min 1): neuron index of current word.
REQ-014 SHALL have port ovf  output  1: one-cycle pulse when an offered frame is dropped.

Function
REQ-015 SHALL store accepted frames in a NUM_BUF-entry frame FIFO (write pointer, read pointer, occupancy count 0..NUM_BUF).
REQ-016 SHALL drive in_ready = (count < NUM_BUF) || (out_valid && out_ready && out_last), combinationally.
REQ-017 SHALL capture in_data on the clk edge where in_valid && in_ready; a frame offered with in_ready low SHALL be dropped and ovf pulse high for the next cycle.
REQ-018 SHALL run a read FSM: IDLE (count==0, out_valid low) and SEND (count>0, out_valid high); IDLE->SEND on capture, SEND->IDLE on final-word transfer with no other frame stored or being captured.
REQ-019 SHALL raise out_valid in the cycle after capture (latency 1 cycle from in_valid to first word).
REQ-020 SHALL present words in order neuron 0..NN-1, out_data = slice out_idx of the head frame; out_data/out_idx/out_last SHALL hold stable while out_valid && !out_ready.
REQ-021 SHALL increment out_idx on each transfer; on the transfer with out_idx==NN-1 it SHALL wrap to 0 and free the head frame, emitting exactly NN words per frame (no extra or missing beat).
REQ-022 SHALL sustain one word per cycle across frame boundaries when a next frame is stored (no bubble between frames).
REQ-023 SHALL, on simultaneous capture and head-frame release, keep count unchanged and advance both pointers.
REQ-024 SHALL support NN==1: every word has out_last high and out_idx 0.

Reset
REQ-025 SHALL, while rst_n low, clear count, pointers, out_idx and FSM to IDLE: out_valid 0, out_last 0, out_idx 0, ovf 0, out_data 0; stored frames are discarded.
REQ-026 SHALL, on reset assertion mid-frame, abort the frame immediately; no partial frame SHALL be resumed after release.

Configuration
REQ-027 SHALL, with macro LAYER_SERIALIZER_OVF_CNT_EN defined, add output ovf_cnt (16 bits) counting dropped frames, saturating at 16'hFFFF, cleared by reset.
REQ-028 SHALL, without LAYER_SERIALIZER_OVF_CNT_EN, omit port ovf_cnt and its counter; all other behaviour identical.

Structure
REQ-029 SHALL take defaults for data width and per-layer neuron counts from the shared include file constants (dataWidth, numNeuronLayerN); index width function clog2 SHALL live in the shared package.
REQ-030 SHALL keep the frame FIFO as one sub-module, frame_buf (parametrised width NN*DATA_WIDTH, depth NUM_BUF); FSM and index counter stay in layer_serializer.

Verification
REQ-031 NN=4, DW=16, out_ready=1; frame {4,3,2,1} (neuron0=1) -> words 1,2,3,4 on 4 consecutive cycles starting 1 cycle after in_valid, out_last only on 4.
REQ-032 NN=4, NUM_BUF=2; two frames 1 cycle apart -> 8 contiguous words, no bubble, idx 0..3,0..3.
REQ-033 NN=4, NUM_BUF=2, out_ready=0; three frames -> third dropped, ovf pulse once, ovf_cnt=1 (macro on); release -> exactly 8 words.
REQ-034 NN=4; out_ready toggled 1,0,0,1,... -> out_data/out_idx held while stalled, still 4 words in order.
REQ-035 NUM_BUF=2 full, new frame offered on cycle of last-word transfer -> captured (in_ready high), no ovf.
REQ-036 rst_n low after 2 of 4 words -> out_valid 0 asynchronously; after release next frame starts at idx 0.

Source files
------------

// File: rtl/layer_serializer_pkg.sv
// rtl/layer_serializer_pkg.sv - shared layer constants, read-FSM states and index-width helper
package layer_serializer_pkg;

  localparam int dataWidth       = 16;
  localparam int numNeuronLayer1 = 30;
  localparam int numNeuronLayer2 = 30;
  localparam int numNeuronLayer3 = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } rd_state_e;

  // Ceiling log2 with a floor of 1 so single-entry indices still get a bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/frame_buf.sv
// rtl/frame_buf.sv - DEPTH-entry frame FIFO; head frame always visible on rd_data
module frame_buf
  import layer_serializer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic [clog2(DEPTH+1)-1:0]    count
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    // Simultaneous write and release leaves occupancy unchanged.
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/layer_serializer.sv
// rtl/layer_serializer.sv - parallel neuron frame to serial word stream
// Optional saturating drop counter output ovf_cnt under LAYER_SERIALIZER_OVF_CNT_EN.
module layer_serializer
  import layer_serializer_pkg::*;
#(
  parameter int NN         = numNeuronLayer1,
  parameter int DATA_WIDTH = dataWidth,
  parameter int NUM_BUF    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [NN*DATA_WIDTH-1:0] in_data,
  output logic                     in_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [clog2(NN)-1:0]     out_idx,
  output logic                     ovf
`ifdef LAYER_SERIALIZER_OVF_CNT_EN
  ,
  output logic [15:0]              ovf_cnt
`endif
);

  localparam int IW = clog2(NN);
  localparam int CW = clog2(NUM_BUF + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NN - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(NUM_BUF);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  rd_state_e                state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic                     ovf_q, ovf_d;
  logic [NN*DATA_WIDTH-1:0] head_frame;
  logic [CW-1:0]            buf_count;
  logic                     capture, xfer, release_head;

  assign out_valid    = (state_q == ST_SEND);
  assign out_idx      = idx_q;
  assign out_last     = out_valid && (idx_q == IDX_LAST);
  assign xfer         = out_valid && out_ready;
  assign release_head = xfer && out_last;
  assign in_ready     = (buf_count != CNT_FULL) || release_head;
  assign capture      = in_valid && in_ready;
  assign out_data     = out_valid ? head_frame[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign ovf          = ovf_q;

  frame_buf #(
    .WIDTH (NN * DATA_WIDTH),
    .DEPTH (NUM_BUF)
  ) u_frame_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (capture),
    .wr_data (in_data),
    .rd_en   (release_head),
    .rd_data (head_frame),
    .count   (buf_count)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ovf_d   = in_valid && !in_ready;
    if (xfer) idx_d = out_last ? '0 : idx_q + 1'b1;
    case (state_q)
      ST_IDLE: if (capture) state_d = ST_SEND;
      // Stay in SEND when another frame is queued or arriving on this same edge.
      ST_SEND: if (release_head && !capture && (buf_count == CNT_ONE)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef LAYER_SERIALIZER_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_d && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_cnt_q <= '0;
    else        ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_layer_serializer.sv
// tb/tb_layer_serializer.sv - randomized and directed bench with a frame-queue reference model
module tb_layer_serializer;

  localparam int NN = 4;
  localparam int DW = 16;
  localparam int NB = 2;
  localparam int FW = NN * DW;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, out_last, ovf;
  logic [FW-1:0] in_data;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_idx;

  logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last, s_ovf;
  logic [DW-1:0] s_in_data, s_out_data;
  logic [0:0]    s_out_idx;
`ifdef LAYER_SERIALIZER_OVF_CNT_EN
  logic [15:0]   ovf_cnt, s_ovf_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  layer_serializer #(.NN(NN), .DATA_WIDTH(DW), .NUM_BUF(NB)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_idx   (out_idx),
    .ovf       (ovf)
`ifdef LAYER_SERIALIZER_OVF_CNT_EN
    ,
    .ovf_cnt   (ovf_cnt)
`endif
  );

  layer_serializer #(.NN(1), .DATA_WIDTH(DW), .NUM_BUF(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_in_valid),
    .in_data   (s_in_data),
    .in_ready  (s_in_ready),
    .out_data  (s_out_data),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_last  (s_out_last),
    .out_idx   (s_out_idx),
    .ovf       (s_ovf)
`ifdef LAYER_SERIALIZER_OVF_CNT_EN
    ,
    .ovf_cnt   (s_ovf_cnt)
`endif
  );

  // Reference model: queue of held frames plus position within the head frame.
  logic [FW-1:0] model_q[$];
  int            pos = 0;
  int            xfers = 0;
  int            captured = 0;
  int            mdl_ovf_total = 0;
  logic          exp_ovf = 1'b0;
  logic          m_valid, m_ready;
  logic [FW-1:0] m_head;
  logic [DW-1:0] m_word;

  always @(negedge clk) begin
    if (!rst_n) begin
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_idx !== '0 || out_last !== 1'b0 || ovf !== 1'b0) begin
        errors++;
        $display("FAIL mon_reset valid=%b data=%h idx=%0d last=%b ovf=%b expected all zero",
                 out_valid, out_data, out_idx, out_last, ovf);
      end
      model_q.delete();
      pos = 0;
      exp_ovf = 1'b0;
      mdl_ovf_total = 0;
    end else begin
      m_valid = (model_q.size() > 0);
      m_ready = (model_q.size() < NB) || (m_valid && out_ready && pos == NN - 1);
      checks++;
      if (out_valid !== m_valid) begin
        errors++;
        $display("FAIL mon_out_valid got %b expected %b", out_valid, m_valid);
      end
      checks++;
      if (in_ready !== m_ready) begin
        errors++;
        $display("FAIL mon_in_ready got %b expected %b", in_ready, m_ready);
      end
      checks++;
      if (ovf !== exp_ovf) begin
        errors++;
        $display("FAIL mon_ovf got %b expected %b", ovf, exp_ovf);
      end
`ifdef LAYER_SERIALIZER_OVF_CNT_EN
      checks++;
      if (ovf_cnt !== 16'(mdl_ovf_total)) begin
        errors++;
        $display("FAIL mon_ovf_cnt got %0d expected %0d", ovf_cnt, mdl_ovf_total);
      end
`endif
      if (m_valid) begin
        m_head = model_q[0];
        m_word = m_head[pos*DW +: DW];
        checks++;
        if (out_data !== m_word || out_idx !== IW'(pos) || out_last !== (pos == NN - 1)) begin
          errors++;
          $display("FAIL mon_word got data=%h idx=%0d last=%b expected data=%h idx=%0d last=%b",
                   out_data, out_idx, out_last, m_word, pos, (pos == NN - 1));
        end
      end
      if (m_valid && out_ready) begin
        xfers++;
        if (pos == NN - 1) begin
          pos = 0;
          void'(model_q.pop_front());
        end else begin
          pos++;
        end
      end
      exp_ovf = in_valid && !m_ready;
      if (in_valid && m_ready) begin
        model_q.push_back(in_data);
        captured++;
      end
      if (exp_ovf) mdl_ovf_total++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] r;
    for (int i = 0; i < NN; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h expected 0", out_data); end
    checks++; if (out_idx !== '0) begin errors++; $display("FAIL reset_out_idx got %0d expected 0", out_idx); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b expected 0", out_last); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b expected 0", ovf); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_frame();
    out_ready = 1'b1;
    in_data = {16'd4, 16'd3, 16'd2, 16'd1};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < NN; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== DW'(k + 1) || out_last !== (k == NN - 1)) begin
        errors++;
        $display("FAIL single_word%0d got valid=%b data=%0d last=%b expected valid=1 data=%0d last=%b",
                 k, out_valid, out_data, out_last, k + 1, (k == NN - 1));
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_end_valid got %b expected 0", out_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      in_data = rand_frame();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    // First word was already presented during the second offer; check the remaining seven.
    for (int k = 1; k < 2 * NN; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_idx !== IW'(k % NN)) begin
        errors++;
        $display("FAIL b2b_beat%0d got valid=%b idx=%0d expected valid=1 idx=%0d", k, out_valid, out_idx, k % NN);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got %b expected 0", out_valid); end
    tick();
  endtask

  task automatic test_overflow();
    int pulses;
    int x0;
    out_ready = 1'b0;
    for (int f = 0; f < 3; f++) begin
      in_data = rand_frame();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ovf === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL ovf_pulses got %0d expected 1", pulses); end
`ifdef LAYER_SERIALIZER_OVF_CNT_EN
    checks++;
    if (ovf_cnt !== 16'd1) begin errors++; $display("FAIL ovf_cnt got %0d expected 1", ovf_cnt); end
`endif
    tick();
    x0 = xfers;
    out_ready = 1'b1;
    repeat (12) tick();
    checks++;
    if (xfers - x0 != 2 * NN) begin errors++; $display("FAIL ovf_drain_words got %0d expected %0d", xfers - x0, 2 * NN); end
  endtask

  task automatic test_stall();
    logic [FW-1:0] fr;
    logic [DW-1:0] prev_data;
    logic [IW-1:0] prev_idx;
    logic          prev_stall;
    int            n;
    fr = rand_frame();
    in_data = fr;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_idx = '0;
    for (int c = 0; c < 16; c++) begin
      out_ready = (c % 3 == 0);
      @(negedge clk);
      if (out_valid && prev_stall) begin
        checks++;
        if (out_data !== prev_data || out_idx !== prev_idx) begin
          errors++;
          $display("FAIL stall_hold got data=%h idx=%0d expected data=%h idx=%0d", out_data, out_idx, prev_data, prev_idx);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== fr[n*DW +: DW]) begin
          errors++;
          $display("FAIL stall_word%0d got %h expected %h", n, out_data, fr[n*DW +: DW]);
        end
        n++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      prev_idx = out_idx;
      tick();
    end
    checks++;
    if (n != NN) begin errors++; $display("FAIL stall_count got %0d expected %0d", n, NN); end
  endtask

  task automatic test_full_release();
    int x0;
    out_ready = 1'b0;
    for (int f = 0; f < 2; f++) begin
      in_data = rand_frame();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b expected 0", in_ready); end
    tick();
    x0 = xfers;
    out_ready = 1'b1;
    tick(); tick(); tick();
    in_data = rand_frame();
    in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL full_release got in_ready=%b last=%b expected in_ready=1 last=1", in_ready, out_last);
    end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL full_release_ovf got %b expected 0", ovf); end
    repeat (14) tick();
    checks++;
    if (xfers - x0 != 3 * NN) begin errors++; $display("FAIL full_release_words got %0d expected %0d", xfers - x0, 3 * NN); end
  endtask

  task automatic test_random();
    int x0, c0;
    x0 = xfers;
    c0 = captured;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 2) == 0);
      in_data = rand_frame();
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (12) tick();
    checks++;
    if (xfers - x0 != (captured - c0) * NN) begin
      errors++;
      $display("FAIL random_word_total got %0d expected %0d", xfers - x0, (captured - c0) * NN);
    end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL random_drained got valid=%b expected 0", out_valid); end
  endtask

  task automatic test_mid_reset();
    logic [FW-1:0] fr;
    out_ready = 1'b1;
    in_data = rand_frame();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_idx !== '0) begin
      errors++;
      $display("FAIL midreset_async got valid=%b idx=%0d expected valid=0 idx=0", out_valid, out_idx);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    fr = rand_frame();
    in_data = fr;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== '0 || out_data !== fr[DW-1:0]) begin
      errors++;
      $display("FAIL midreset_restart got valid=%b idx=%0d data=%h expected valid=1 idx=0 data=%h",
               out_valid, out_idx, out_data, fr[DW-1:0]);
    end
`ifdef LAYER_SERIALIZER_OVF_CNT_EN
    checks++;
    if (ovf_cnt !== 16'd0) begin errors++; $display("FAIL midreset_ovf_cnt got %0d expected 0", ovf_cnt); end
`endif
    repeat (6) tick();
  endtask

  task automatic test_nn1();
    logic [DW-1:0] a, c;
    a = DW'($urandom);
    c = DW'($urandom);
    s_out_ready = 1'b0;
    s_in_data = a;
    s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (s_out_valid !== 1'b1 || s_out_last !== 1'b1 || s_out_idx !== 1'b0 || s_out_data !== a || s_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL nn1_first got valid=%b last=%b idx=%0d data=%h in_ready=%b expected 1 1 0 %h 0",
               s_out_valid, s_out_last, s_out_idx, s_out_data, s_in_ready, a);
    end
    tick();
    s_in_data = DW'($urandom);
    s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ovf !== 1'b1) begin errors++; $display("FAIL nn1_ovf got %b expected 1", s_ovf); end
    tick();
    s_out_ready = 1'b1;
    s_in_data = c;
    s_in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (s_in_ready !== 1'b1 || s_out_data !== a) begin
      errors++;
      $display("FAIL nn1_release got in_ready=%b data=%h expected in_ready=1 data=%h", s_in_ready, s_out_data, a);
    end
    tick();
    s_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (s_out_valid !== 1'b1 || s_out_data !== c || s_out_last !== 1'b1 || s_ovf !== 1'b0) begin
      errors++;
      $display("FAIL nn1_second got valid=%b data=%h last=%b ovf=%b expected 1 %h 1 0",
               s_out_valid, s_out_data, s_out_last, s_ovf, c);
    end
    tick();
    @(negedge clk);
    checks++;
    if (s_out_valid !== 1'b0) begin errors++; $display("FAIL nn1_end_valid got %b expected 0", s_out_valid); end
`ifdef LAYER_SERIALIZER_OVF_CNT_EN
    checks++;
    if (s_ovf_cnt !== 16'd1) begin errors++; $display("FAIL nn1_ovf_cnt got %0d expected 1", s_ovf_cnt); end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_stall();
    test_full_release();
    test_random();
    test_mid_reset();
    test_nn1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
